// File: rtl/dmem_bus_ctrl_if.sv
// rtl/dmem_bus_ctrl_if.sv - valid/ready data-bus bundle between the memory controller and the external data bus
//
// Purpose: groups the request and response wires of the external data bus.
// Signals:
//   bus_addr   32  word-aligned address of the transfer
//   bus_wdata  32  store data
//   bus_wstrb   4  byte strobes, 0000 for loads
//   bus_we      1  1 = store, 0 = load
//   bus_valid   1  request valid
//   bus_ready   1  slave accepts/completes the transfer this cycle
//   bus_rdata  32  read data, valid when bus_valid & bus_ready & ~bus_we
// Modports: master (controller side), slave (memory/bus side).

interface dmem_bus_ctrl_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_we;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_wstrb, bus_we, bus_valid,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_wstrb, bus_we, bus_valid,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// rtl/dmem_bus_ctrl.sv - data-memory access controller between load/store alignment logic and the data bus
//
// Purpose: issues one load or store per request on a valid/ready bus, stalls the
// pipeline until it completes, flags misaligned requests and aborts hung
// transfers after TIMEOUT bus cycles.
// Ports:
//   clk, resetn        clock and synchronous active-low reset
//   addr               byte address of the access
//   memRead, memWrite  level requests, held while stall is high (both = store)
//   data_width         00 byte, 01 half-word, 10 word, 11 illegal
//   wr_datatoMem       lane-aligned store data
//   mask_data          byte-write mask
//   data_mem           registered raw word returned by the last load
//   stall              combinational pipeline freeze
//   mis_align          combinational misaligned / illegal-size flag in IDLE
//   bus_err            one-cycle pulse on timeout abort
//   bus                data-bus bundle (master side)

module dmem_bus_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           addr,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [1:0]            data_width,
  input  logic [31:0]           wr_datatoMem,
  input  logic [3:0]            mask_data,
  output logic [31:0]           data_mem,
  output logic                  stall,
  output logic                  mis_align,
  output logic                  bus_err,
  dmem_bus_ctrl_if.master       bus
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic       req;
  logic       bad_size;
  logic       issue;
  logic       hit;
  logic       expire;

  always_comb begin
    req        = memRead | memWrite;
    bad_size   = (data_width == 2'b11)
               | ((data_width == 2'b01) & addr[0])
               | ((data_width == 2'b10) & (addr[1:0] != 2'b00));
    mis_align  = req & (state == S_IDLE) & bad_size;
    issue      = 1'b0;
    hit        = 1'b0;
    expire     = 1'b0;
    stall      = 1'b0;
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req && !bad_size) begin
          issue      = 1'b1;
          stall      = 1'b1;
          state_next = S_BUS;
        end
      end
      S_BUS: begin
        stall = 1'b1;
        // A response arriving on the last allowed cycle still counts as success.
        if (bus.bus_ready) begin
          hit        = 1'b1;
          state_next = S_DONE;
        end else if (cnt == LAST_CNT) begin
          expire     = 1'b1;
          state_next = S_DONE;
        end
      end
      // DONE ignores req so the instruction that just finished is not re-issued.
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt           <= 8'd0;
      bus.bus_valid <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_wstrb <= 4'b0000;
      bus.bus_addr  <= 32'd0;
      bus.bus_wdata <= 32'd0;
      data_mem      <= 32'd0;
      bus_err       <= 1'b0;
    end else begin
      bus_err <= expire;
      if (issue) begin
        bus.bus_valid <= 1'b1;
        bus.bus_addr  <= {addr[31:2], 2'b00};
        bus.bus_we    <= memWrite;
        bus.bus_wstrb <= memWrite ? mask_data : 4'b0000;
        bus.bus_wdata <= memWrite ? wr_datatoMem : 32'd0;
        cnt           <= 8'd0;
      end
      if (state == S_BUS) begin
        cnt <= cnt + 8'd1;
      end
      if (hit || expire) begin
        bus.bus_valid <= 1'b0;
        cnt           <= 8'd0;
      end
      if (hit && !bus.bus_we) begin
        data_mem <= bus.bus_rdata;
      end
      // An aborted load hands the extractor a defined zero rather than stale data.
      if (expire && !bus.bus_we) begin
        data_mem <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb/tb_dmem_bus_ctrl.sv - self-checking bench for dmem_bus_ctrl

module tb_dmem_bus_ctrl;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        resetn;
  logic [31:0] addr;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  data_width;
  logic [31:0] wr_datatoMem;
  logic [3:0]  mask_data;
  logic [31:0] data_mem;
  logic        stall;
  logic        mis_align;
  logic        bus_err;

  dmem_bus_ctrl_if bif ();

  dmem_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .addr         (addr),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .data_width   (data_width),
    .wr_datatoMem (wr_datatoMem),
    .mask_data    (mask_data),
    .data_mem     (data_mem),
    .stall        (stall),
    .mis_align    (mis_align),
    .bus_err      (bus_err),
    .bus          (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected per-cycle view, written by the stimulus tasks.
  bit          chk_en = 1'b0;
  bit          exp_stall, exp_mis, exp_valid, exp_err, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  logic [31:0] model_dmem;

  // Running observations of the DUT, used for the literal window checks.
  int          obs_stall = 0, obs_valid = 0, obs_err = 0, obs_mis = 0, obs_we_cyc = 0;
  logic [31:0] obs_addr = 32'd0;
  logic [3:0]  obs_wstrb = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("mis_align", 32'(mis_align), 32'(exp_mis));
      check("bus_valid", 32'(bif.bus_valid), 32'(exp_valid));
      check("bus_err", 32'(bus_err), 32'(exp_err));
      check("data_mem", data_mem, model_dmem);
      if (exp_valid) begin
        check("bus_addr", bif.bus_addr, exp_addr);
        check("bus_we", 32'(bif.bus_we), 32'(exp_we));
        check("bus_wstrb", 32'(bif.bus_wstrb), 32'(exp_wstrb));
        if (exp_we) check("bus_wdata", bif.bus_wdata, exp_wdata);
      end
      obs_stall  += int'(stall);
      obs_valid  += int'(bif.bus_valid);
      obs_err    += int'(bus_err);
      obs_mis    += int'(mis_align);
      obs_we_cyc += int'(bif.bus_valid & bif.bus_we);
      if (bif.bus_valid) begin
        obs_addr  = bif.bus_addr;
        obs_wstrb = bif.bus_wstrb;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    memRead      = 1'b0;
    memWrite     = 1'b0;
    addr         = $urandom;
    data_width   = 2'($urandom);
    bif.bus_ready = 1'($urandom);
    bif.bus_rdata = $urandom;
    exp_stall = 1'b0; exp_mis = 1'b0; exp_valid = 1'b0; exp_err = 1'b0;
    step();
  endtask

  // One access from its IDLE cycle through DONE. The slave answers after
  // wait_n valid cycles; wait_n >= TIMEOUT means it never answers in time.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [1:0] w,
                        input logic [31:0] wd, input logic [3:0] m, input int wait_n,
                        input logic [31:0] rword, input bit hold_done);
    bit mis;
    bit ok;
    int nv;
    mis = (w == 2'b11) || (w == 2'b01 && a[0]) || (w == 2'b10 && a[1:0] != 2'b00);
    ok  = wait_n < TIMEOUT;
    nv  = ok ? wait_n + 1 : TIMEOUT;
    memWrite = wr; memRead = rd; addr = a; data_width = w;
    wr_datatoMem = wd; mask_data = wr ? m : 4'b0000;
    bif.bus_ready = 1'($urandom);
    bif.bus_rdata = $urandom;
    exp_stall = !mis; exp_mis = mis; exp_valid = 1'b0; exp_err = 1'b0;
    step();
    if (mis) begin
      memRead = 1'b0; memWrite = 1'b0;
      return;
    end
    exp_addr = {a[31:2], 2'b00}; exp_we = wr; exp_wstrb = wr ? m : 4'b0000; exp_wdata = wd;
    for (int i = 0; i < nv; i++) begin
      addr = $urandom; data_width = 2'($urandom); wr_datatoMem = $urandom;
      bif.bus_ready = (i == wait_n);
      bif.bus_rdata = (i == wait_n) ? rword : $urandom;
      exp_stall = 1'b1; exp_mis = 1'b0; exp_valid = 1'b1; exp_err = 1'b0;
      step();
    end
    if (!hold_done) begin
      memRead = 1'b0; memWrite = 1'b0;
    end
    bif.bus_ready = 1'($urandom);
    bif.bus_rdata = $urandom;
    exp_stall = 1'b0; exp_mis = 1'b0; exp_valid = 1'b0; exp_err = !ok;
    if (!wr) model_dmem = ok ? rword : 32'd0;
    step();
  endtask

  int s0, v0, e0, m0, w0;
  task automatic snap();
    s0 = obs_stall; v0 = obs_valid; e0 = obs_err; m0 = obs_mis; w0 = obs_we_cyc;
  endtask

  initial begin
    resetn = 1'b0; memRead = 1'b0; memWrite = 1'b0; addr = 32'd0; data_width = 2'b00;
    wr_datatoMem = 32'd0; mask_data = 4'd0; bif.bus_ready = 1'b0; bif.bus_rdata = 32'd0;
    model_dmem = 32'd0;
    exp_stall = 0; exp_mis = 0; exp_valid = 0; exp_err = 0; exp_we = 0;
    exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
    repeat (3) step();
    check("rst_valid", 32'(bif.bus_valid), 32'd0);
    check("rst_addr", bif.bus_addr, 32'd0);
    check("rst_wdata", bif.bus_wdata, 32'd0);
    check("rst_wstrb", 32'(bif.bus_wstrb), 32'd0);
    check("rst_we", 32'(bif.bus_we), 32'd0);
    check("rst_data_mem", data_mem, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    resetn = 1'b1;
    chk_en = 1'b1;
    idle_cycle();

    // Load word, zero wait.
    snap();
    access(0, 1, 32'h0000_0104, 2'b10, 32'd0, 4'd0, 0, 32'hDEAD_BEEF, 0);
    check("ldw_stall_cycles", 32'(obs_stall - s0), 32'd2);
    check("ldw_valid_cycles", 32'(obs_valid - v0), 32'd1);
    check("ldw_bus_addr", obs_addr, 32'h0000_0104);
    check("ldw_wstrb", 32'(obs_wstrb), 32'd0);
    check("ldw_data", data_mem, 32'hDEAD_BEEF);

    // Store byte, three wait states.
    snap();
    access(1, 0, 32'h0000_0203, 2'b00, 32'hAB00_0000, 4'b1000, 3, 32'd0, 0);
    check("stb_valid_cycles", 32'(obs_valid - v0), 32'd4);
    check("stb_stall_cycles", 32'(obs_stall - s0), 32'd5);
    check("stb_we_cycles", 32'(obs_we_cyc - w0), 32'd4);
    check("stb_bus_addr", obs_addr, 32'h0000_0200);
    check("stb_wstrb", 32'(obs_wstrb), 32'b1000);
    check("stb_data_kept", data_mem, 32'hDEAD_BEEF);

    // Misaligned and illegal-size requests.
    snap();
    access(0, 1, 32'h0000_0101, 2'b01, 32'd0, 4'd0, 0, 32'd0, 0);
    access(0, 1, 32'h0000_0102, 2'b10, 32'd0, 4'd0, 0, 32'd0, 0);
    access(0, 1, 32'h0000_0100, 2'b11, 32'd0, 4'd0, 0, 32'd0, 0);
    check("mis_count", 32'(obs_mis - m0), 32'd3);
    check("mis_no_valid", 32'(obs_valid - v0), 32'd0);
    check("mis_no_stall", 32'(obs_stall - s0), 32'd0);
    idle_cycle();

    // Timeout with the slave silent.
    snap();
    access(0, 1, 32'h0000_0400, 2'b10, 32'd0, 4'd0, 40, 32'h5555_5555, 0);
    check("to_valid_cycles", 32'(obs_valid - v0), 32'd16);
    check("to_err_pulses", 32'(obs_err - e0), 32'd1);
    check("to_stall_cycles", 32'(obs_stall - s0), 32'd17);
    check("to_data_zero", data_mem, 32'd0);

    // Slave answers on the 16th valid cycle.
    snap();
    access(0, 1, 32'h0000_0408, 2'b10, 32'd0, 4'd0, 15, 32'h1234_5678, 0);
    check("last_valid_cycles", 32'(obs_valid - v0), 32'd16);
    check("last_err_pulses", 32'(obs_err - e0), 32'd0);
    check("last_data", data_mem, 32'h1234_5678);

    // Reset during the second BUS cycle of a load.
    memRead = 1'b1; memWrite = 1'b0; addr = 32'h0000_0300; data_width = 2'b10;
    bif.bus_ready = 1'b0;
    exp_stall = 1; exp_mis = 0; exp_valid = 0; exp_err = 0;
    step();
    exp_addr = 32'h0000_0300; exp_we = 0; exp_wstrb = 0; exp_valid = 1;
    step();
    resetn = 1'b0; memRead = 1'b0;
    step();
    resetn = 1'b1;
    model_dmem = 32'd0;
    exp_stall = 0; exp_valid = 0; exp_err = 0; exp_mis = 0;
    check("mid_rst_data", data_mem, 32'd0);
    check("mid_rst_addr", bif.bus_addr, 32'd0);
    check("mid_rst_valid", 32'(bif.bus_valid), 32'd0);
    step();
    snap();
    access(0, 1, 32'h0000_0310, 2'b10, 32'd0, 4'd0, 1, 32'hCAFE_F00D, 0);
    check("post_rst_data", data_mem, 32'hCAFE_F00D);
    check("post_rst_valid_cycles", 32'(obs_valid - v0), 32'd2);

    // Back-to-back store then load with requests held through DONE.
    snap();
    access(1, 0, 32'h0000_0500, 2'b10, 32'h0BAD_F00D, 4'b1111, 0, 32'd0, 1);
    access(0, 1, 32'h0000_0504, 2'b10, 32'd0, 4'd0, 0, 32'h7777_1111, 0);
    check("b2b_store_cycles", 32'(obs_we_cyc - w0), 32'd1);
    check("b2b_valid_cycles", 32'(obs_valid - v0), 32'd2);
    check("b2b_data", data_mem, 32'h7777_1111);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_cycle();
      end else begin
        bit          wr;
        bit          rd;
        logic [31:0] a;
        logic [1:0]  w;
        int          wt;
        wr = 1'($urandom);
        rd = wr ? 1'($urandom) : 1'b1;
        w  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        a  = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (w == 2'b01) a[0] = 1'b0;
          if (w == 2'b10) a[1:0] = 2'b00;
        end
        wt = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4)
                                         : $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
        access(wr, rd, a, w, $urandom, 4'($urandom), wt, $urandom, 1'($urandom));
      end
    end
    idle_cycle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
